// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: default data
// width, the canonical NOP encoding and the {pc, inst} entry layout that
// queues between Fetch and Decode/Execute store.
package pipe_pkg;

    // Default width of pc and instruction fields.
    localparam int PIPE_XLEN = 32;

    // Default queue depth for fetch-side buffers.
    localparam int FETCH_DEPTH = 4;

    // add x0,x0,x0 -- architecturally inert filler for empty slots.
    localparam logic [PIPE_XLEN-1:0] PIPE_NOP_INST = 32'h0000_0033;

    // One queued fetch result.
    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_fifo_ctrl.sv
// fifo_ctrl: pointer and occupancy bookkeeping for a power-of-two circular
// queue. Storage lives in the instantiating module; this block only decides
// where the next write lands, which slot is the head, and how full it is.
// Pointers wrap naturally at their own width; occupancy comes from the count,
// so a full and an empty queue are never confused.
module fifo_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Never write past a full queue or read from an empty one, even if the
    // caller forgets to gate its requests.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state: flush rewinds everything, otherwise advance pointers and
    // adjust the count by the net of push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset to an empty queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign wr_ptr_o = wr_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry instruction queue between Fetch and
// Decode/Execute. Fetch keeps pushing {pc, inst} while the consumer stalls; a
// single flush pulse (branch/trap redirect) empties it. When nothing valid is
// at the head the consumer sees NOP_INST with pc 0.
//
// Build option FETCH_BUF_BYPASS_EN: when the queue is empty, an offered entry
// is forwarded combinationally to out_* in the same cycle. If the consumer
// takes it, it is never stored; otherwise it is enqueued as usual. Without
// the macro there is no in->out combinational path and latency is one cycle.
//
// XLEN must match pipe_pkg::PIPE_XLEN because entries use the shared
// fetch_entry_t layout.
module fetch_buffer
    import pipe_pkg::*;
#(
    parameter int               XLEN     = PIPE_XLEN,
    parameter int               DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0]  NOP_INST = PIPE_NOP_INST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage; contents are never reset, only invalidated by the count.
    fetch_entry_t mem_q [DEPTH];

    fetch_entry_t     in_entry;
    fetch_entry_t     head_entry;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign in_entry.pc   = in_pc;
    assign in_entry.inst = in_inst;
    assign head_entry    = mem_q[rd_ptr];

    // in_ready depends only on occupancy: no path from out_ready or flush_i.
    assign in_ready = ~full;

`ifdef FETCH_BUF_BYPASS_EN
    // Empty queue with a live offer: forward it straight to the consumer.
    assign bypass = empty & in_valid & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that the consumer takes this cycle is not stored.
    assign push = in_valid & ~full & ~flush_i & ~(bypass & out_ready);
    // Only stored entries are popped; a bypassed one never reached storage.
    assign pop  = ~empty & out_ready & ~flush_i;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .push_i   (push),
        .pop_i    (pop),
        .rd_ptr_o (rd_ptr),
        .wr_ptr_o (wr_ptr),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Write the offered entry into the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= in_entry;
        end
    end

    // Consumer view: stored head if any, else the bypassed offer, else NOP.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = NOP_INST;
        if (!empty) begin
            out_valid = 1'b1;
            out_pc    = head_entry.pc;
            out_inst  = head_entry.inst;
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    assign count_o = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer. A scoreboard queue mirrors the
// expected contents: accepted pushes are appended, consumed heads are popped
// and compared against out_pc/out_inst. Occupancy, in_ready and out_valid are
// checked every cycle against the scoreboard size.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0033;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count_o;

    ent_t sb[$];
    int   total  = 0;
    int   passed = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count_o   (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check outputs at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic tick();
        bit          e_v;
        bit          byp;
        bit          acc;
        bit          rd;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        int          sz;
        @(negedge clk);
        sz     = sb.size();
        e_v    = 1'b0;
        byp    = 1'b0;
        e_pc   = 32'h0;
        e_inst = NOP;
        if (sz != 0) begin
            e_v    = 1'b1;
            e_pc   = sb[0].pc;
            e_inst = sb[0].inst;
        end
`ifdef FETCH_BUF_BYPASS_EN
        else if (in_valid && !flush_i) begin
            byp    = 1'b1;
            e_v    = 1'b1;
            e_pc   = in_pc;
            e_inst = in_inst;
        end
`endif
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(e_v));
            chk("out_pc",    64'(out_pc),    64'(e_pc));
            chk("out_inst",  64'(out_inst),  64'(e_inst));
            chk("in_ready",  64'(in_ready),  64'(sz != DEPTH));
            chk("count_o",   64'(count_o),   64'(sz));
        end
        if (rst || flush_i) begin
            sb.delete();
        end else begin
            acc = in_valid && (sz < DEPTH) && !(byp && out_ready);
            rd  = (sz != 0) && out_ready;
            if (rd) void'(sb.pop_front());
            if (acc) sb.push_back('{pc: in_pc, inst: in_inst});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush_i   = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Reset: first edge establishes state, second cycle checks reset values.
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Fill to capacity with the consumer stalled; fifth push must be refused.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 4), 32'h0050_0093 + 32'(i << 20), 1'b0, 1'b0);
            tick();
        end

        // Drain from full, then observe the empty NOP view.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();

        // Streaming push and pop, pointers wrap twice.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 32'h0010_0113 + 32'(i << 20), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        // Build count=3, then flush while pushing and popping.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h00A0_0513 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h300, 32'hDEAD_0013, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        // Reset mid-stream with two entries queued, then refill.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h80 + 32'(i * 4), 32'h0030_0193 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h90, 32'h0000_0001, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h100, 32'h0040_0213, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        // Empty queue, offer with consumer ready (zero-latency case when bypass
        // is built in, ordinary one-cycle path otherwise).
        drive(1'b1, 32'h40, 32'h0070_0393, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        // Empty queue, offer with consumer stalled: must be stored.
        drive(1'b1, 32'h44, 32'h0080_0413, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
